// File: rtl/axi_sram_slave.sv
// AXI4 slave front-end for a single-port 32-bit word SRAM.
// One transaction in flight at a time; INCR/WRAP (treated as INCR) and FIXED bursts of
// 1-16 beats; byte-strobed writes. AxSIZE is ignored and the stride is always one word.
// Optional build macro AXI_SLV_DECERR_EN: accesses outside the SRAM window are flagged
// at the address handshake and answered with DECERR without touching the SRAM.
// Without it, out-of-window addresses alias modulo the SRAM size.
module axi_sram_slave #(
  parameter int unsigned ID_W      = 8,
  parameter int unsigned MEM_AW    = 14,
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000
) (
  input  logic              clk,
  input  logic              rst,
  // write address
  input  logic [ID_W-1:0]   AWID,
  input  logic [31:0]       AWADDR,
  input  logic [3:0]        AWLEN,
  input  logic [2:0]        AWSIZE,
  input  logic [1:0]        AWBURST,
  input  logic              AWVALID,
  output logic              AWREADY,
  // write data
  input  logic [31:0]       WDATA,
  input  logic [3:0]        WSTRB,
  input  logic              WLAST,
  input  logic              WVALID,
  output logic              WREADY,
  // write response
  output logic [ID_W-1:0]   BID,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  // read address
  input  logic [ID_W-1:0]   ARID,
  input  logic [31:0]       ARADDR,
  input  logic [3:0]        ARLEN,
  input  logic [2:0]        ARSIZE,
  input  logic [1:0]        ARBURST,
  input  logic              ARVALID,
  output logic              ARREADY,
  // read data
  output logic [ID_W-1:0]   RID,
  output logic [31:0]       RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY,
  // SRAM macro
  output logic              mem_cs,
  output logic [3:0]        mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_di,
  input  logic [31:0]       mem_do
);

  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StRdData,
    StWrData,
    StWrResp
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [3:0]        len_q, len_d;
  logic [3:0]        beat_q, beat_d;
  logic [1:0]        burst_q, burst_d;
  logic              err_q, err_d;   // WLAST placement error seen in this write burst
  logic              dec_q, dec_d;   // burst targets an address outside the SRAM window

  logic [MEM_AW-1:0] addr_nxt;
  logic              last_beat;

  // Size is irrelevant: every beat is one 32-bit word.
  logic unused_size;
  assign unused_size = ^{AWSIZE, ARSIZE};

  function automatic logic [MEM_AW-1:0] word_of(input logic [31:0] a);
    return MEM_AW'((a - BASE_ADDR) >> 2);
  endfunction

`ifdef AXI_SLV_DECERR_EN
  function automatic logic addr_bad(input logic [31:0] a);
    return (a < BASE_ADDR) || (((a - BASE_ADDR) >> (MEM_AW + 2)) != 32'd0);
  endfunction
`endif

  // FIXED holds the address; INCR and WRAP both step one word, wrapping at the SRAM top.
  assign addr_nxt  = (burst_q == 2'b00) ? addr_q : addr_q + MEM_AW'(1);
  assign last_beat = (beat_q == len_q);

  // State and transaction context registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      burst_q <= '0;
      err_q   <= 1'b0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      burst_q <= burst_d;
      err_q   <= err_d;
      dec_q   <= dec_d;
    end
  end

  // Next-state and output decode; outputs forced idle while rst is high so an aborted
  // burst drops its handshakes immediately.
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    addr_d   = addr_q;
    len_d    = len_q;
    beat_d   = beat_q;
    burst_d  = burst_q;
    err_d    = err_q;
    dec_d    = dec_q;

    AWREADY  = 1'b0;
    WREADY   = 1'b0;
    BID      = '0;
    BRESP    = 2'b00;
    BVALID   = 1'b0;
    ARREADY  = 1'b0;
    RID      = '0;
    RDATA    = '0;
    RRESP    = 2'b00;
    RLAST    = 1'b0;
    RVALID   = 1'b0;
    mem_cs   = 1'b0;
    mem_we   = 4'b0000;
    mem_addr = '0;
    mem_di   = '0;

    if (!rst) begin
      unique case (state_q)
        StIdle: begin
          AWREADY = 1'b1;
          ARREADY = !AWVALID;  // write has priority; AR waits
          if (AWVALID) begin
            state_d = StWrData;
            id_d    = AWID;
            len_d   = AWLEN;
            burst_d = AWBURST;
            addr_d  = word_of(AWADDR);
            beat_d  = '0;
            err_d   = 1'b0;
`ifdef AXI_SLV_DECERR_EN
            dec_d   = addr_bad(AWADDR);
`else
            dec_d   = 1'b0;
`endif
          end else if (ARVALID) begin
            state_d = StRdReq;
            id_d    = ARID;
            len_d   = ARLEN;
            burst_d = ARBURST;
            addr_d  = word_of(ARADDR);
            beat_d  = '0;
            err_d   = 1'b0;
`ifdef AXI_SLV_DECERR_EN
            dec_d   = addr_bad(ARADDR);
`else
            dec_d   = 1'b0;
`endif
          end
        end

        StRdReq: begin
          mem_cs   = !dec_q;
          mem_addr = addr_q;
          state_d  = StRdData;
        end

        StRdData: begin
          // mem_do holds until the next access, so the beat is stable under backpressure.
          RVALID = 1'b1;
          RID    = id_q;
          RDATA  = dec_q ? 32'h0 : mem_do;
          RRESP  = dec_q ? 2'b11 : 2'b00;
          RLAST  = last_beat;
          if (RREADY) begin
            if (last_beat) begin
              state_d = StIdle;
            end else begin
              beat_d  = beat_q + 4'd1;
              addr_d  = addr_nxt;
              state_d = StRdReq;
            end
          end
        end

        StWrData: begin
          WREADY   = 1'b1;
          mem_cs   = WVALID && !dec_q;
          mem_we   = (WVALID && !dec_q) ? WSTRB : 4'b0000;
          mem_addr = addr_q;
          mem_di   = WDATA;
          if (WVALID) begin
            // The beat counter ends the burst; WLAST only feeds the error flag.
            if (last_beat) begin
              err_d   = err_q | !WLAST;
              state_d = StWrResp;
            end else begin
              err_d  = err_q | WLAST;
              beat_d = beat_q + 4'd1;
              addr_d = addr_nxt;
            end
          end
        end

        StWrResp: begin
          BVALID = 1'b1;
          BID    = id_q;
          BRESP  = dec_q ? 2'b11 : (err_q ? 2'b10 : 2'b00);
          if (BREADY) begin
            state_d = StIdle;
          end
        end

        default: state_d = StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave: a behavioural SRAM behind the DUT, a bench-side
// reference memory that predicts read data, and R/B scoreboards compared at handshakes.
module tb_axi_sram_slave;

  localparam int unsigned ID_W   = 8;
  localparam int unsigned MEM_AW = 14;
  localparam logic [31:0] BASE   = 32'h0001_0000;

  logic              clk;
  logic              rst;
  logic [ID_W-1:0]   AWID;
  logic [31:0]       AWADDR;
  logic [3:0]        AWLEN;
  logic [2:0]        AWSIZE;
  logic [1:0]        AWBURST;
  logic              AWVALID;
  logic              AWREADY;
  logic [31:0]       WDATA;
  logic [3:0]        WSTRB;
  logic              WLAST;
  logic              WVALID;
  logic              WREADY;
  logic [ID_W-1:0]   BID;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;
  logic [ID_W-1:0]   ARID;
  logic [31:0]       ARADDR;
  logic [3:0]        ARLEN;
  logic [2:0]        ARSIZE;
  logic [1:0]        ARBURST;
  logic              ARVALID;
  logic              ARREADY;
  logic [ID_W-1:0]   RID;
  logic [31:0]       RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY;
  logic              mem_cs;
  logic [3:0]        mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_di;
  logic [31:0]       mem_do;

  axi_sram_slave #(
    .ID_W     (ID_W),
    .MEM_AW   (MEM_AW),
    .BASE_ADDR(BASE)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .AWID    (AWID),
    .AWADDR  (AWADDR),
    .AWLEN   (AWLEN),
    .AWSIZE  (AWSIZE),
    .AWBURST (AWBURST),
    .AWVALID (AWVALID),
    .AWREADY (AWREADY),
    .WDATA   (WDATA),
    .WSTRB   (WSTRB),
    .WLAST   (WLAST),
    .WVALID  (WVALID),
    .WREADY  (WREADY),
    .BID     (BID),
    .BRESP   (BRESP),
    .BVALID  (BVALID),
    .BREADY  (BREADY),
    .ARID    (ARID),
    .ARADDR  (ARADDR),
    .ARLEN   (ARLEN),
    .ARSIZE  (ARSIZE),
    .ARBURST (ARBURST),
    .ARVALID (ARVALID),
    .ARREADY (ARREADY),
    .RID     (RID),
    .RDATA   (RDATA),
    .RRESP   (RRESP),
    .RLAST   (RLAST),
    .RVALID  (RVALID),
    .RREADY  (RREADY),
    .mem_cs  (mem_cs),
    .mem_we  (mem_we),
    .mem_addr(mem_addr),
    .mem_di  (mem_di),
    .mem_do  (mem_do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: registered read, byte-enabled write, output held between reads.
  logic [31:0] sram [0:(1<<MEM_AW)-1];
  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_we == 4'b0000) begin
        mem_do <= sram[mem_addr];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (mem_we[b]) sram[mem_addr][8*b +: 8] <= mem_di[8*b +: 8];
        end
      end
    end
  end

  // Reference memory maintained by the bench from the writes it issues.
  logic [31:0] model_mem [0:(1<<MEM_AW)-1];
  logic [31:0] wbuf [0:15];

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  id;
    logic        last;
    logic [1:0]  resp;
  } r_exp_t;
  typedef struct packed {
    logic [7:0] id;
    logic [1:0] resp;
  } b_exp_t;

  r_exp_t rq[$];
  b_exp_t bq[$];
  r_exp_t re;
  b_exp_t be;

  int n_checks = 0;
  int n_pass   = 0;
  int cs_cnt   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [MEM_AW-1:0] word_of(input logic [31:0] a);
    return MEM_AW'((a - BASE) >> 2);
  endfunction

  function automatic logic sig_of(input int which);
    case (which)
      0:       return AWREADY;
      1:       return WREADY;
      2:       return ARREADY;
      3:       return RVALID;
      default: return BVALID;
    endcase
  endfunction

  // Monitor: compare R and B beats against the scoreboards at each handshake.
  always @(negedge clk) begin
    if (!rst && RVALID && RREADY) begin
      if (rq.size() == 0) begin
        check_eq("r_unexpected_beat", 32'(rq.size()), 32'd1);
      end else begin
        re = rq.pop_front();
        check_eq("rdata", RDATA, re.data);
        check_eq("rid", 32'(RID), 32'(re.id));
        check_eq("rlast", 32'(RLAST), 32'(re.last));
        check_eq("rresp", 32'(RRESP), 32'(re.resp));
      end
    end
    if (!rst && BVALID && BREADY) begin
      if (bq.size() == 0) begin
        check_eq("b_unexpected", 32'(bq.size()), 32'd1);
      end else begin
        be = bq.pop_front();
        check_eq("bid", 32'(BID), 32'(be.id));
        check_eq("bresp", 32'(BRESP), 32'(be.resp));
      end
    end
    if (mem_cs) cs_cnt++;
  end

  task automatic wait_sig(input string tag, input int which);
    int n;
    n = 0;
    @(negedge clk);
    while (!sig_of(which) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(sig_of(which)), 32'd1);
  endtask

  task automatic wait_rq_empty();
    int n;
    n = 0;
    while (rq.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("r_drain", 32'(rq.size()), 32'd0);
  endtask

  task automatic wait_bq_empty();
    int n;
    n = 0;
    while (bq.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("b_drain", 32'(bq.size()), 32'd0);
  endtask

  task automatic ar_hs(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                       input logic [1:0] burst);
    ARID = id; ARADDR = addr; ARLEN = len; ARBURST = burst; ARVALID = 1'b1;
    wait_sig("arready", 2);
    @(posedge clk); #1;
    ARVALID = 1'b0;
  endtask

  task automatic rd_burst(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [1:0] burst);
    logic [MEM_AW-1:0] wa;
    wa = word_of(addr);
    for (int i = 0; i <= int'(len); i++) begin
      rq.push_back('{data: model_mem[wa], id: id, last: (i == int'(len)), resp: 2'b00});
      if (burst != 2'b00) wa = wa + MEM_AW'(1);
    end
    ar_hs(id, addr, len, burst);
    wait_rq_empty();
  endtask

  // last_at: beat index carrying WLAST (len for a well-formed burst).
  task automatic wr_burst(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [1:0] burst, input logic [3:0] strb, input int last_at);
    logic [MEM_AW-1:0] wa;
    logic              err;
    wa  = word_of(addr);
    err = 1'b0;
    AWID = id; AWADDR = addr; AWLEN = len; AWBURST = burst; AWVALID = 1'b1;
    wait_sig("awready", 0);
    @(posedge clk); #1;
    AWVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      WVALID = 1'b1; WDATA = wbuf[i]; WSTRB = strb; WLAST = (i == last_at);
      if ((i == int'(len)) != (i == last_at)) err = 1'b1;
      wait_sig("wready", 1);
      @(posedge clk); #1;
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) model_mem[wa][8*b +: 8] = wbuf[i][8*b +: 8];
      end
      if (burst != 2'b00) wa = wa + MEM_AW'(1);
    end
    WVALID = 1'b0; WLAST = 1'b0;
    bq.push_back('{id: id, resp: (err ? 2'b10 : 2'b00)});
    wait_bq_empty();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cs0;
    rst = 1'b1;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1'b0;
    RREADY = 1'b1;
    sram[0] = 32'hDEAD_BEEF;
    model_mem[0] = 32'hDEAD_BEEF;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_awready", 32'(AWREADY), 32'd0);
    check_eq("rst_arready", 32'(ARREADY), 32'd0);
    check_eq("rst_wready", 32'(WREADY), 32'd0);
    check_eq("rst_bvalid", 32'(BVALID), 32'd0);
    check_eq("rst_rvalid", 32'(RVALID), 32'd0);
    check_eq("rst_mem_cs", 32'(mem_cs), 32'd0);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("idle_awready", 32'(AWREADY), 32'd1);

    // Single read with latency: RVALID low one cycle after handshake, high the next
    rq.push_back('{data: model_mem[0], id: 8'h12, last: 1'b1, resp: 2'b00});
    ar_hs(8'h12, BASE, 4'd0, 2'b01);
    check_eq("rd_lat_c1", 32'(RVALID), 32'd0);
    @(posedge clk); #1;
    check_eq("rd_lat_c2", 32'(RVALID), 32'd1);
    wait_rq_empty();

    // INCR write burst to words 4..7, then read it back
    wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
    wr_burst(8'h03, BASE + 32'h10, 4'd3, 2'b01, 4'hF, 3);
    rd_burst(8'h05, BASE + 32'h10, 4'd3, 2'b01);

    // Read backpressure: beat held stable, no extra SRAM access
    RREADY = 1'b0;
    rq.push_back('{data: model_mem[5], id: 8'h06, last: 1'b1, resp: 2'b00});
    ar_hs(8'h06, BASE + 32'h14, 4'd0, 2'b01);
    wait_sig("bp_rvalid", 3);
    cs0 = cs_cnt;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_eq("bp_rdata", RDATA, model_mem[5]);
      check_eq("bp_rlast", 32'(RLAST), 32'd1);
    end
    check_eq("bp_no_cs", 32'(cs_cnt), 32'(cs0));
    RREADY = 1'b1;
    wait_rq_empty();

    // Byte strobes over an all-ones word
    wbuf[0] = 32'hFFFF_FFFF;
    wr_burst(8'h07, BASE + 32'h20, 4'd0, 2'b01, 4'hF, 0);
    wbuf[0] = 32'hAABB_CCDD;
    wr_burst(8'h08, BASE + 32'h20, 4'd0, 2'b01, 4'b0011, 0);
    rd_burst(8'h09, BASE + 32'h20, 4'd0, 2'b01);

    // Simultaneous AW and AR: write first, AR waits until the B handshake
    AWID = 8'h0A; AWADDR = BASE + 32'h40; AWLEN = 4'd0; AWBURST = 2'b01; AWVALID = 1'b1;
    ARID = 8'h0B; ARADDR = BASE + 32'h40; ARLEN = 4'd0; ARBURST = 2'b01; ARVALID = 1'b1;
    BREADY = 1'b0;
    @(negedge clk);
    check_eq("sim_awready", 32'(AWREADY), 32'd1);
    check_eq("sim_arready", 32'(ARREADY), 32'd0);
    @(posedge clk); #1;
    AWVALID = 1'b0;
    WVALID = 1'b1; WDATA = 32'h5A5A_1234; WSTRB = 4'hF; WLAST = 1'b1;
    @(negedge clk);
    check_eq("sim_wr_arready", 32'(ARREADY), 32'd0);
    @(posedge clk); #1;
    WVALID = 1'b0; WLAST = 1'b0;
    model_mem[16] = 32'h5A5A_1234;
    bq.push_back('{id: 8'h0A, resp: 2'b00});
    rq.push_back('{data: model_mem[16], id: 8'h0B, last: 1'b1, resp: 2'b00});
    @(negedge clk);
    check_eq("sim_bvalid", 32'(BVALID), 32'd1);
    check_eq("sim_b_arready", 32'(ARREADY), 32'd0);
    BREADY = 1'b1;
    wait_bq_empty();
    wait_sig("sim_ar_late", 2);
    @(posedge clk); #1;
    ARVALID = 1'b0;
    wait_rq_empty();

    // Premature WLAST: both beats still written, SLVERR
    wbuf[0] = 32'h111; wbuf[1] = 32'h222;
    wr_burst(8'h0C, BASE + 32'h60, 4'd1, 2'b01, 4'hF, 0);
    rd_burst(8'h0D, BASE + 32'h60, 4'd1, 2'b01);

    // FIXED burst: every beat lands on the same word
    wbuf[0] = 32'hA; wbuf[1] = 32'hB; wbuf[2] = 32'hC;
    wr_burst(8'h0E, BASE + 32'h78, 4'd2, 2'b00, 4'hF, 2);
    rd_burst(8'h0F, BASE + 32'h78, 4'd1, 2'b00);

    // INCR wraps from the top word back to word 0
    wbuf[0] = 32'h77; wbuf[1] = 32'h88;
    wr_burst(8'h10, BASE + 32'hFFFC, 4'd1, 2'b01, 4'hF, 1);
    rd_burst(8'h11, BASE + 32'hFFFC, 4'd1, 2'b10);

    // Reset during beat 2 of a 4-beat read
    for (int i = 0; i < 4; i++) begin
      rq.push_back('{data: model_mem[4+i], id: 8'h01, last: (i == 3), resp: 2'b00});
    end
    ar_hs(8'h01, BASE + 32'h10, 4'd3, 2'b01);
    n = 0;
    while (rq.size() != 3 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("rst_first_beat", 32'(rq.size()), 32'd3);
    RREADY = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_beat2_rvalid", 32'(RVALID), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("rst_abort_rvalid", 32'(RVALID), 32'd0);
    @(posedge clk); #1;
    check_eq("rst_mid_rvalid", 32'(RVALID), 32'd0);
    check_eq("rst_mid_rlast", 32'(RLAST), 32'd0);
    check_eq("rst_mid_rresp", 32'(RRESP), 32'd0);
    check_eq("rst_mid_mem_cs", 32'(mem_cs), 32'd0);
    check_eq("rst_mid_awready", 32'(AWREADY), 32'd0);
    check_eq("rst_mid_bvalid", 32'(BVALID), 32'd0);
    rst = 1'b0;
    rq.delete();
    #1;
    check_eq("rst_idle_awready", 32'(AWREADY), 32'd1);
    check_eq("rst_idle_arready", 32'(ARREADY), 32'd1);
    RREADY = 1'b1;
    rd_burst(8'h02, BASE + 32'h10, 4'd1, 2'b01);

    // Address below the window
`ifdef AXI_SLV_DECERR_EN
    rq.push_back('{data: 32'h0, id: 8'h44, last: 1'b1, resp: 2'b11});
    cs0 = cs_cnt;
    ar_hs(8'h44, 32'h0000_0000, 4'd0, 2'b01);
    wait_rq_empty();
    check_eq("decerr_no_cs", 32'(cs_cnt), 32'(cs0));
`else
    rd_burst(8'h44, 32'h0000_0000, 4'd0, 2'b01);
`endif

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
